// File: rtl/serial_divider_pkg.sv
// serial_divider_pkg: shared funct codes, FSM states and width default for the divider
package serial_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_divider_div_step.sv
// div_step: one restoring-division iteration using a borrow subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] trial;
  // shifted remainder needs WIDTH+1 bits; the extra top bit of the difference is the borrow
  assign sh       = {rem, msb};
  assign trial    = {1'b0, sh} - {2'b00, divisor};
  assign qbit     = ~trial[WIDTH+1];
  assign next_rem = qbit ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/serial_divider.sv
// serial_divider: multi-cycle restoring divider; signed DIV support under DIVIDER_SIGNED_EN
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int         WIDTH = DEF_WIDTH,
  parameter logic [5:0] DIVU  = FN_DIVU,
  parameter logic [5:0] DIV   = FN_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divZero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, a_mag, b_mag, nrem;
  logic acc, sgn, neg_q, neg_r, qbit;
`ifdef DIVIDER_SIGNED_EN
  assign sgn = Signal == DIV;
  assign acc = start && (Signal == DIVU || sgn);
`else
  assign sgn = 1'b0;
  assign acc = start && Signal == DIVU;
`endif
  assign a_mag = (sgn && dataA[WIDTH-1]) ? -dataA : dataA;
  assign b_mag = (sgn && dataB[WIDTH-1]) ? -dataB : dataB;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .msb(quo[WIDTH-1]), .divisor(dvs), .next_rem(nrem), .qbit(qbit)
  );
  always_comb begin
    nxt = state == IDLE ? (acc ? (dataB == '0 ? DONE : RUN) : IDLE)
        : state == RUN  ? (cnt == CW'(WIDTH) ? DONE : RUN)
        : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      divZero   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && acc) begin
        rem     <= '0;
        quo     <= a_mag;
        dvs     <= b_mag;
        cnt     <= '0;
        divZero <= dataB == '0;
        neg_q   <= sgn && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
        neg_r   <= sgn && dataA[WIDTH-1];
        if (dataB == '0) begin
          quotient  <= '1;
          remainder <= dataA;
        end
      end else if (state == RUN) begin
        if (cnt != CW'(WIDTH)) begin
          rem <= nrem;
          quo <= {quo[WIDTH-2:0], qbit};
          cnt <= cnt + 1'b1;
        end else begin
          quotient  <= neg_q ? -quo : quo;
          remainder <= neg_r ? -rem : rem;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider: table-driven self-checking bench for serial_divider
module tb_serial_divider;
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] ADD  = 6'b100000;
  localparam int W = 32;
  logic clk = 0, reset = 0, start = 0;
  logic [5:0] Signal = DIVU;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic busy, done, divZero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, failures = 0;

  serial_divider dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .divZero(divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic [5:0]   s;
    logic [W-1:0] q, r;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] s, output int lat);
    @(negedge clk);
    start = 1; dataA = a; dataB = b; Signal = s;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t tbl[$];
    int lat, seen;
    tbl.push_back('{32'd100, 32'd7, DIVU, 32'd14, 32'd2, 1'b0});
    tbl.push_back('{32'h12345678, 32'd0, DIVU, 32'hFFFFFFFF, 32'h12345678, 1'b1});
    tbl.push_back('{32'hFFFFFFFF, 32'd1, DIVU, 32'hFFFFFFFF, 32'd0, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, DIVU, 32'd1, 32'd0, 1'b0});
    tbl.push_back('{32'd5, 32'd10, DIVU, 32'd0, 32'd5, 1'b0});
    tbl.push_back('{32'd0, 32'd3, DIVU, 32'd0, 32'd0, 1'b0});
    tbl.push_back('{32'h80000000, 32'd3, DIVU, 32'h2AAAAAAA, 32'd2, 1'b0});
    tbl.push_back('{32'd1000000, 32'd1000, DIVU, 32'd1000, 32'd0, 1'b0});
`ifdef DIVIDER_SIGNED_EN
    tbl.push_back('{32'hFFFFFFF9, 32'd2, DIV, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'd7, 32'hFFFFFFFE, DIV, 32'hFFFFFFFD, 32'd1, 1'b0});
    tbl.push_back('{32'hFFFFFFF9, 32'hFFFFFFFE, DIV, 32'd3, 32'hFFFFFFFF, 1'b0});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", {31'd0, divZero}, 0);
    reset = 1;

    foreach (tbl[i]) begin
      @(negedge clk);
      start = 1; dataA = tbl[i].a; dataB = tbl[i].b; Signal = tbl[i].s;
      @(negedge clk);
      start = 0;
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 1);
      lat = 1;
      while (!done && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      if (tbl[i].b == 0) chk($sformatf("v%0d_lat", i), {31'd0, lat <= 2}, 1);
      else chk($sformatf("v%0d_lat", i), lat, W + 2);
      chk($sformatf("v%0d_q", i), quotient, tbl[i].q);
      chk($sformatf("v%0d_r", i), remainder, tbl[i].r);
      chk($sformatf("v%0d_dz", i), {31'd0, divZero}, {31'd0, tbl[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {30'd0, done, busy}, 0);
    end

`ifndef DIVIDER_SIGNED_EN
    @(negedge clk);
    start = 1; Signal = DIV; dataA = 32'd9; dataB = 32'd2;
    @(negedge clk);
    start = 0;
    chk("div_ignored_busy", {31'd0, busy}, 0);
    chk("div_ignored_q", quotient, tbl[tbl.size()-1].q);
`endif

    @(negedge clk);
    start = 1; Signal = DIVU; dataA = 32'hFFFFFFFF; dataB = 32'd1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    start = 1; dataA = 32'd10; dataB = 32'd2;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_start_q", quotient, 32'hFFFFFFFF);
    chk("busy_start_r", remainder, 0);
    @(negedge clk);
    start = 1; Signal = ADD; dataA = 32'd50; dataB = 32'd5;
    @(negedge clk);
    start = 0;
    chk("add_ignored_busy", {31'd0, busy}, 0);
    chk("add_ignored_q", quotient, 32'hFFFFFFFF);
    Signal = DIVU;

    @(negedge clk);
    start = 1; dataA = 32'd100; dataB = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run_op(32'd9, 32'd3, DIVU, lat);
    chk("after_rst_lat", lat, W + 2);
    chk("after_rst_q", quotient, 32'd3);
    chk("after_rst_r", remainder, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
